// File: rtl/axis_inject_arbiter_if.sv
// rtl/axis_inject_arbiter_if.sv - per-source request streams and the shared mesh injection stream
interface axis_inject_arbiter_if #(
  parameter int NUM_SOURCES = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TDEST_WIDTH = 4
);
  localparam int SRC_W = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0]             s_tvalid;
  logic [NUM_SOURCES-1:0]             s_tready;
  logic [NUM_SOURCES*TDATA_WIDTH-1:0] s_tdata;
  logic [NUM_SOURCES-1:0]             s_tlast;
  logic [NUM_SOURCES*TDEST_WIDTH-1:0] s_tdest;

  logic                   m_tvalid;
  logic                   m_tready;
  logic [TDATA_WIDTH-1:0] m_tdata;
  logic                   m_tlast;
  logic [TDEST_WIDTH-1:0] m_tdest;
  logic [SRC_W-1:0]       m_tid;

  modport master (
    input  s_tvalid, s_tdata, s_tlast, s_tdest, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tdest, m_tid
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, s_tdest, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tdest, m_tid
  );
endinterface

// File: rtl/axis_inject_arbiter.sv
// rtl/axis_inject_arbiter.sv - round-robin packet-atomic arbiter onto one registered AXIS injection port
// Optional stall watchdog under AXIS_ARB_WATCHDOG_EN.
module axis_inject_arbiter #(
  parameter int NUM_SOURCES     = 4,
  parameter int TDATA_WIDTH     = 512,
  parameter int TDEST_WIDTH     = 4,
  parameter int WATCHDOG_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axis_inject_arbiter_if.master    bus,
  output logic                     timeout_err
);
  localparam int SRC_W = $clog2(NUM_SOURCES);

  if (NUM_SOURCES < 2 || WATCHDOG_CYCLES < 1) begin : g_param_check
    $error("axis_inject_arbiter: NUM_SOURCES must be >= 2 and WATCHDOG_CYCLES >= 1");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] grant_q, grant_d;

  logic                   main_valid_q, main_valid_d;
  logic [TDATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                   main_last_q, main_last_d;
  logic [TDEST_WIDTH-1:0] main_dest_q, main_dest_d;
  logic [SRC_W-1:0]       main_id_q, main_id_d;

  logic                   spare_valid_q, spare_valid_d;
  logic [TDATA_WIDTH-1:0] spare_data_q, spare_data_d;
  logic                   spare_last_q, spare_last_d;
  logic [TDEST_WIDTH-1:0] spare_dest_q, spare_dest_d;
  logic [SRC_W-1:0]       spare_id_q, spare_id_d;

  logic                   space;
  logic                   idle_found;
  logic [SRC_W-1:0]       idle_sel;
  logic [SRC_W-1:0]       scan_idx;
  logic [SRC_W-1:0]       cur;
  logic                   offer;
  logic [NUM_SOURCES-1:0] s_tready_c;
  logic                   accept;
  logic                   pop;
  logic [TDATA_WIDTH-1:0] in_data;
  logic                   in_last;
  logic [TDEST_WIDTH-1:0] in_dest;
  logic [SRC_W-1:0]       rr_next;

  assign space = !spare_valid_q;
  assign pop   = main_valid_q && bus.m_tready;

  // Rotating scan starting at rr_ptr; the first requester found wins.
  always_comb begin
    idle_found = 1'b0;
    idle_sel   = '0;
    scan_idx   = '0;
    for (int j = 0; j < NUM_SOURCES; j++) begin
      scan_idx = SRC_W'((int'(rr_ptr_q) + j) % NUM_SOURCES);
      if (!idle_found && bus.s_tvalid[scan_idx]) begin
        idle_found = 1'b1;
        idle_sel   = scan_idx;
      end
    end
  end

  assign cur   = (state_q == LOCKED) ? grant_q : idle_sel;
  assign offer = (state_q == LOCKED) || idle_found;

  always_comb begin
    s_tready_c = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      s_tready_c[i] = rst_n && space && offer && (cur == SRC_W'(i));
    end
  end

  assign accept       = |(bus.s_tvalid & s_tready_c);
  assign bus.s_tready = s_tready_c;

  always_comb begin
    in_data = '0;
    in_last = 1'b0;
    in_dest = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (cur == SRC_W'(i)) begin
        in_data = bus.s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        in_last = bus.s_tlast[i];
        in_dest = bus.s_tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
      end
    end
  end

  assign rr_next = (cur == SRC_W'(NUM_SOURCES - 1)) ? '0 : cur + SRC_W'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    if (accept) begin
      if (in_last) begin
        state_d  = IDLE;
        rr_ptr_d = rr_next;
      end else begin
        state_d = LOCKED;
        grant_d = cur;
      end
    end
  end

  // Skid: main feeds the port; spare only fills when main is stalled.
  always_comb begin
    main_valid_d  = main_valid_q;
    main_data_d   = main_data_q;
    main_last_d   = main_last_q;
    main_dest_d   = main_dest_q;
    main_id_d     = main_id_q;
    spare_valid_d = spare_valid_q;
    spare_data_d  = spare_data_q;
    spare_last_d  = spare_last_q;
    spare_dest_d  = spare_dest_q;
    spare_id_d    = spare_id_q;
    if (!main_valid_q || pop) begin
      if (spare_valid_q) begin
        main_valid_d  = 1'b1;
        main_data_d   = spare_data_q;
        main_last_d   = spare_last_q;
        main_dest_d   = spare_dest_q;
        main_id_d     = spare_id_q;
        spare_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = in_data;
          main_last_d = in_last;
          main_dest_d = in_dest;
          main_id_d   = cur;
        end
      end
    end else if (accept) begin
      spare_valid_d = 1'b1;
      spare_data_d  = in_data;
      spare_last_d  = in_last;
      spare_dest_d  = in_dest;
      spare_id_d    = cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      main_valid_q  <= 1'b0;
      main_data_q   <= '0;
      main_last_q   <= 1'b0;
      main_dest_q   <= '0;
      main_id_q     <= '0;
      spare_valid_q <= 1'b0;
      spare_data_q  <= '0;
      spare_last_q  <= 1'b0;
      spare_dest_q  <= '0;
      spare_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      main_valid_q  <= main_valid_d;
      main_data_q   <= main_data_d;
      main_last_q   <= main_last_d;
      main_dest_q   <= main_dest_d;
      main_id_q     <= main_id_d;
      spare_valid_q <= spare_valid_d;
      spare_data_q  <= spare_data_d;
      spare_last_q  <= spare_last_d;
      spare_dest_q  <= spare_dest_d;
      spare_id_q    <= spare_id_d;
    end
  end

  assign bus.m_tvalid = main_valid_q;
  assign bus.m_tdata  = main_data_q;
  assign bus.m_tlast  = main_last_q;
  assign bus.m_tdest  = main_dest_q;
  assign bus.m_tid    = main_id_q;

`ifdef AXIS_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  // Counts only while the locked owner is idle; the lock itself is never broken.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == LOCKED && !accept && !bus.s_tvalid[grant_q]) begin
      wd_cnt_d = (wd_cnt_q == WD_W'(WATCHDOG_CYCLES)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
    end
    timeout_d = timeout_q || (wd_cnt_d == WD_W'(WATCHDOG_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_axis_inject_arbiter.sv
// tb/tb_axis_inject_arbiter.sv - scoreboard bench for axis_inject_arbiter
module tb_axis_inject_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int WD = 8;

  typedef struct packed {
    logic [1:0]  tid;
    logic [3:0]  dest;
    logic        last;
    logic [31:0] data;
  } flit_t;

  logic clk;
  logic rst_n;
  logic timeout_err;

  axis_inject_arbiter_if #(.NUM_SOURCES(NS), .TDATA_WIDTH(DW), .TDEST_WIDTH(TW)) bus ();

  axis_inject_arbiter #(
    .NUM_SOURCES(NS), .TDATA_WIDTH(DW), .TDEST_WIDTH(TW), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .timeout_err(timeout_err)
  );

  flit_t          src_q[NS][$];
  flit_t          exp_q[$];
  int             out_cyc[$];
  int             tid_cnt[NS];
  int             n_chk = 0;
  int             n_pass = 0;
  int             cyc = 0;
  int             acc_cyc = 0;
  int             out_last_cyc = 0;
  int             mode = 0;
  logic [NS-1:0]  hs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic flit_t mk(input int src, input int dest, input bit last, input int data);
    flit_t f;
    f.tid  = 2'(src);
    f.dest = 4'(dest);
    f.last = last;
    f.data = 32'(data);
    return f;
  endfunction

  task automatic add(input int src, input int dest, input bit last, input int data, input bit expect_it);
    flit_t f;
    f = mk(src, dest, last, data);
    src_q[src].push_back(f);
    if (expect_it) exp_q.push_back(f);
  endtask

  task automatic add_pkt(input int src, input int n, input int dest, input int base);
    for (int k = 0; k < n; k++) add(src, dest, (k == n - 1), base + k, 1'b1);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic sample_point();
    @(negedge clk);
    #4;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending()) && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  // Source drivers and output monitor share one loop so sampling order is fixed.
  initial begin
    flit_t got, e;
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    bus.s_tdest  = '0;
    bus.m_tready = 1'b1;
    forever begin
      @(negedge clk);
      case (mode)
        0:       bus.m_tready = 1'b1;
        1:       bus.m_tready = ~bus.m_tready;
        default: bus.m_tready = 1'b0;
      endcase
      for (int i = 0; i < NS; i++) begin
        if (src_q[i].size() > 0) begin
          bus.s_tvalid[i]           = 1'b1;
          bus.s_tdata[i*DW +: DW]   = src_q[i][0].data;
          bus.s_tlast[i]            = src_q[i][0].last;
          bus.s_tdest[i*TW +: TW]   = src_q[i][0].dest;
        end else begin
          bus.s_tvalid[i] = 1'b0;
          bus.s_tlast[i]  = 1'b0;
        end
      end
      #4;
      hs = '0;
      if (rst_n) begin
        if (bus.m_tvalid && bus.m_tready) begin
          got = {bus.m_tid, bus.m_tdest, bus.m_tlast, bus.m_tdata};
          if (exp_q.size() == 0) begin
            chk("extra_flit", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("flit", got, e);
          end
          out_cyc.push_back(cyc);
          out_last_cyc = cyc;
          tid_cnt[bus.m_tid]++;
        end
        hs = bus.s_tvalid & bus.s_tready;
        if (hs != '0) acc_cyc = cyc;
      end
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NS; i++) if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: run did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    sample_point();
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_m_tdata", bus.m_tdata, 0);
    chk("rst_m_tid_last", {bus.m_tid, bus.m_tlast, bus.m_tdest}, 0);
    chk("rst_timeout", timeout_err, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // single flit from src1, one-cycle latency
    @(posedge clk);
    add(1, 1, 1'b1, 1, 1'b1);
    drain("single_drain", 50);
    chk("single_latency", out_last_cyc - acc_cyc, 1);

    // rr_ptr now 2: simultaneous singles come out 2,3,0,1
    @(posedge clk);
    add(2, 2, 1'b1, 32'h20, 1'b1);
    add(3, 3, 1'b1, 32'h30, 1'b1);
    add(0, 0, 1'b1, 32'h00, 1'b1);
    add(1, 1, 1'b1, 32'h10, 1'b1);
    drain("rr_order_drain", 50);
    @(posedge clk);
    add(3, 5, 1'b1, 32'h31, 1'b1);
    drain("pre_contention_drain", 50);

    // contention: src0 then src2, three flits each, contiguous
    out_cyc.delete();
    @(posedge clk);
    add_pkt(0, 3, 6, 32'h100);
    add_pkt(2, 3, 7, 32'h200);
    drain("contention_drain", 100);
    chk("contention_count", out_cyc.size(), 6);
    chk("contention_no_bubble", out_cyc[5] - out_cyc[0], 5);
    @(posedge clk);
    add(3, 9, 1'b1, 32'h32, 1'b1);
    drain("pre_fair_drain", 50);

    // fairness over 400 single-flit packets
    for (int i = 0; i < NS; i++) tid_cnt[i] = 0;
    @(posedge clk);
    for (int r = 0; r < 100; r++)
      for (int s = 0; s < NS; s++) add(s, s + 8, 1'b1, 32'h1000 + r * 4 + s, 1'b1);
    drain("fair_drain", 1000);
    for (int i = 0; i < NS; i++) chk("fair_share", tid_cnt[i], 100);

    // m_tready toggling during a 5-flit packet
    @(posedge clk);
    mode = 1;
    add_pkt(1, 5, 12, 32'h500);
    drain("toggle_drain", 100);
    mode = 0;

    // sustained stall: skid fills, all s_tready drop, nothing lost
    @(posedge clk);
    mode = 2;
    add_pkt(0, 4, 13, 32'h600);
    repeat (6) @(posedge clk);
    sample_point();
    chk("stall_s_tready", bus.s_tready, 0);
    chk("stall_m_tvalid", bus.m_tvalid, 1);
    mode = 0;
    drain("stall_drain", 100);

    // lock hold: src3 owns the port while idle, src0 waits
    @(posedge clk);
    add(3, 14, 1'b0, 32'h700, 1'b1);
    exp_q.push_back(mk(3, 14, 1'b1, 32'h701));
    add(0, 15, 1'b1, 32'h710, 1'b0);
    exp_q.push_back(mk(0, 15, 1'b1, 32'h710));
    for (int k = 0; k < 20; k++) begin
      sample_point();
      chk("lock_s_tready0", bus.s_tready[0], 0);
    end
`ifdef AXIS_ARB_WATCHDOG_EN
    chk("wd_timeout_set", timeout_err, 1);
`else
    chk("wd_timeout_off", timeout_err, 0);
`endif
    @(posedge clk);
    src_q[3].push_back(mk(3, 14, 1'b1, 32'h701));
    drain("lock_drain", 100);
`ifdef AXIS_ARB_WATCHDOG_EN
    chk("wd_timeout_sticky", timeout_err, 1);
`else
    chk("wd_timeout_still_off", timeout_err, 0);
`endif
    @(posedge clk);
    add(1, 2, 1'b1, 32'h800, 1'b1);
    drain("pre_reset_drain", 50);

    // reset mid-packet with the skid holding flits
    @(posedge clk);
    mode = 2;
    add(2, 3, 1'b0, 32'h900, 1'b0);
    add(2, 3, 1'b0, 32'h901, 1'b0);
    add(2, 3, 1'b1, 32'h902, 1'b0);
    repeat (5) @(posedge clk);
    sample_point();
    chk("pre_reset_m_tvalid", bus.m_tvalid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    sample_point();
    chk("mid_rst_m_tvalid", bus.m_tvalid, 0);
    chk("mid_rst_s_tready", bus.s_tready, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    @(posedge clk);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    mode = 0;

    // after reset: IDLE with rr_ptr 0, so src1 beats src3
    @(posedge clk);
    add(1, 4, 1'b1, 32'hA01, 1'b1);
    add(3, 4, 1'b1, 32'hA03, 1'b1);
    exp_q.delete();
    exp_q.push_back(mk(1, 4, 1'b1, 32'hA01));
    exp_q.push_back(mk(3, 4, 1'b1, 32'hA03));
    drain("post_reset_drain", 50);
    chk("post_reset_timeout", timeout_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_inject_arbiter.md
Name: axis_inject_arbiter

Overview:
Round-robin, packet-atomic arbiter that shares one AXI-Stream injection port of an axis_mesh endpoint among NUM_SOURCES local requesters on the user clock. A grant is held from the first flit to the tlast flit of a packet, so packets never interleave at the mesh input. The source index is forwarded on m_tid. Outputs are fully registered through a 2-entry skid stage.

Parameters:
NUM_SOURCES, 4, number of requesting AXIS sources (>=2)
TDATA_WIDTH, 512, flit data width
TDEST_WIDTH, 4, mesh destination width
SRC_W, $clog2(NUM_SOURCES), source index width (derived, localparam)
WATCHDOG_CYCLES, 256, stall limit used only with AXIS_ARB_WATCHDOG_EN

Ports:
clk  in  1  user clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_tvalid  in  NUM_SOURCES  per-source valid
s_tready  out  NUM_SOURCES  per-source ready
s_tdata  in  NUM_SOURCES*TDATA_WIDTH  packed per-source data, source i at [i*TDATA_WIDTH +: TDATA_WIDTH]
s_tlast  in  NUM_SOURCES  per-source last flit
s_tdest  in  NUM_SOURCES*TDEST_WIDTH  packed per-source destination
m_tvalid  out  1  to mesh axis_in_tvalid
m_tready  in  1  from mesh axis_in_tready
m_tdata  out  TDATA_WIDTH  flit data
m_tlast  out  1  flit last
m_tdest  out  TDEST_WIDTH  flit destination
m_tid  out  SRC_W  index of source that produced the flit
timeout_err  out  1  sticky watchdog flag (tied 0 when feature off)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, grant=0, skid empty; m_tvalid=0, s_tready=0, m_tdata/m_tlast/m_tdest/m_tid=0, timeout_err=0. Mid-packet reset discards the skid contents and any partial packet; no recovery flit is generated.
- Skid stage: main and spare registers. space = !spare_valid (registered). m_* driven from main only. When m_tvalid&&!m_tready and a flit is accepted, the flit goes to spare. When main drains, spare moves to main. Latency: accept at edge N -> m_tvalid at N+1. Throughput: 1 flit/cycle with m_tready=1.
- Arbitration in IDLE (combinational): winner = first i with s_tvalid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_SOURCES. s_tready[winner]=space; all others 0. No valid input -> all s_tready=0.
- LOCKED: s_tready[grant]=space; all others 0, regardless of their valid.
- On accept (s_tvalid[k]&&s_tready[k]): flit plus m_tid=k enters skid. If tlast=0 -> state=LOCKED, grant=k. If tlast=1 -> state=IDLE, rr_ptr=(k+1) mod NUM_SOURCES. A single-flit packet never enters LOCKED.
- A new winner can be accepted in the cycle after a tlast accept, so back-to-back packets have no bubble.
- rr_ptr wraps NUM_SOURCES-1 -> 0. A just-served source has lowest priority in the next arbitration.
- LOCKED with s_tvalid[grant]=0: hold the lock indefinitely; no other source is served.
- m_tready low: s_tready of all sources falls to 0 once spare is full; no flit is dropped or duplicated.

Optional Feature:
Macro AXIS_ARB_WATCHDOG_EN.
- Defined: a counter runs in LOCKED while s_tvalid[grant]=0 and resets on any accept or on leaving LOCKED. When the count reaches WATCHDOG_CYCLES, timeout_err is set and stays set until reset. The lock is not released.
- Undefined: no counter is built; timeout_err is constant 0.

Test Plan:
- Single source: src1 sends 1 flit (tdest=4'h1, tdata=1, tlast=1), m_tready=1 -> m_tvalid one cycle after accept, m_tid=1, then rr_ptr=2.
- Contention: src0 and src2 each hold a 3-flit packet valid from the same cycle -> output is src0 flits 0..2 contiguous, then src2 flits 0..2, no interleave, no bubble, m_tid=0,0,0,2,2,2.
- Fairness: all 4 sources continuously send 1-flit packets -> grant order 0,1,2,3,0,1..., each source gets exactly 25% over 400 flits.
- Backpressure: m_tready toggles 1/0 every cycle during a 5-flit packet -> exactly 5 flits out, in order, data intact, tlast only on the 5th.
- Lock stall: src3 sends flit0 with tlast=0 then drops valid for 20 cycles while src0 is valid -> s_tready[0]=0 throughout; src3 completes before src0 is granted.
- Reset mid-packet, plus watchdog with the macro defined and WATCHDOG_CYCLES=8: stall LOCKED for 8 cycles -> timeout_err=1 and sticky. Assert rst_n=0 -> timeout_err=0, m_tvalid=0, state IDLE, rr_ptr=0.
